mmio_reg_bank: RTL and testbench
================================

MMIO_REG_BANK -- requirements
Module: mmio_reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, register and MMIO data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, MMIO word-address width.
REQ-003 SHALL have parameter START_ADDR, default 'h20, first word address owned by the bank.
REQ-004 SHALL have parameter END_ADDR, default 'h3F, last word address owned by the bank (inclusive).
REQ-005 SHALL have parameter NUM_SW_REGS, default 8, number of software read/write registers.
REQ-006 SHALL have parameter NUM_HW_REGS, default 4, number of hardware read-only status registers.
REQ-007 SHALL have parameter TID_WIDTH, default 9, read transaction-ID width.
REQ-008 SHALL have parameter RD_LATENCY, default 1, legal range 1..4, read-response latency in cycles.
REQ-009 SHALL have port clk, input, 1, the only clock.
REQ-010 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-011 SHALL have ports rd_en (in, 1), rd_addr (in, ADDR_WIDTH) and rd_tid (in, TID_WIDTH), carrying the read request.
REQ-012 SHALL have ports wr_en (in, 1), wr_addr (in, ADDR_WIDTH) and wr_data (in, DATA_WIDTH), carrying the write request.
REQ-013 SHALL have ports rd_valid (out, 1), rd_data (out, DATA_WIDTH) and rd_rsp_tid (out, TID_WIDTH), carrying the read response.
REQ-014 SHALL have port sw_regs, output, NUM_SW_REGS*DATA_WIDTH, all SW registers concatenated with register 0 in the LSBs.
REQ-015 SHALL have port hw_status, input, NUM_HW_REGS*DATA_WIDTH, status words concatenated with word 0 in the LSBs.
REQ-016 SHALL have port go, output, 1, one-cycle start pulse.

Function
REQ-017 SHALL compute offset = addr - START_ADDR; an address is in range iff START_ADDR <= addr <= END_ADDR.
REQ-018 SHALL map offsets 0..NUM_SW_REGS-1 to SW registers and the next NUM_HW_REGS offsets to hw_status words; the remaining in-range offsets are unmapped.
REQ-019 SHALL store wr_data into the addressed SW register on the clock edge of an in-range wr_en, with the new value visible on sw_regs the next cycle.
REQ-020 SHALL ignore writes to HW, unmapped or out-of-range addresses.
REQ-021 SHALL pulse go high for exactly one cycle, the cycle after any write to offset 0 with wr_data[0]=1; the written value is also stored.
REQ-022 SHALL assert rd_valid exactly RD_LATENCY cycles after each in-range rd_en, with rd_rsp_tid equal to that request's rd_tid.
REQ-023 SHALL sample read data in the rd_en cycle; a same-cycle write to the same SW register returns the pre-write value.
REQ-024 SHALL return 0 for reads of unmapped offsets.
REQ-025 SHALL accept one read per cycle with no stall, using a RD_LATENCY-deep valid/tid/data pipeline.
REQ-026 SHALL NOT respond to out-of-range reads: rd_valid stays low and another bank owns the address.
REQ-027 SHALL hold rd_data and rd_rsp_tid at their last value while rd_valid is low.
REQ-028 SHALL accept a simultaneous read and write to different addresses in the same cycle.
REQ-029 SHALL fail elaboration if NUM_SW_REGS+NUM_HW_REGS > END_ADDR-START_ADDR+1, if NUM_SW_REGS < 1, or if RD_LATENCY is outside 1..4.

Reset
REQ-030 SHALL, while rst is high, clear all SW registers, go, rd_valid, rd_data, rd_rsp_tid and every pipeline stage to 0, asynchronously.
REQ-031 SHALL discard reads in flight when reset is asserted; no rd_valid for them appears after rst deasserts.

Configuration
REQ-032 SHALL, when MMIO_ERR_CNT_EN is defined, add output err_count (16 bits, reset 0) that increments by 1 per in-range read or write to an unmapped offset or to a HW offset (writes only), saturating at 'hFFFF.
REQ-033 SHALL count a same-cycle read and write that are both errors as +2.
REQ-034 SHALL, when MMIO_ERR_CNT_EN is undefined, have no err_count port and no counter logic.

Structure
REQ-035 SHALL take from shared package mmio_pkg the maximum-latency constant (4), the error-counter width (16) and the offset-decode typedef.
REQ-036 SHALL use one sub-module, mmio_rd_pipe, as the parametrised RD_LATENCY-stage valid/tid/data delay line.

Verification
REQ-037 SHALL cover: write 'h1234 to addr 'h21, then read with tid 5 -> rd_valid at +RD_LATENCY, rd_data='h1234, rd_rsp_tid=5.
REQ-038 SHALL cover: write 'h1 to 'h20 -> go high exactly one cycle and sw_regs[63:0]='h1.
REQ-039 SHALL cover: RD_LATENCY=3 with reads every cycle, tids 1,2,3,4 -> four consecutive rd_valid cycles in order, tids 1..4.
REQ-040 SHALL cover: read 'h40 (out of range) -> no rd_valid; read 'h2F (unmapped) -> rd_data=0 and, with MMIO_ERR_CNT_EN, err_count=1.
REQ-041 SHALL cover: read 'h22 and write 'hAA to 'h22 in the same cycle -> old value returned, and 'hAA returned on the next read.
REQ-042 SHALL cover: rst asserted with a read in flight at RD_LATENCY=4 -> all outputs 0 and no response after release.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO register bank: the read-latency ceiling,
// the error-counter width and the address-decode classification.
package mmio_pkg;

  localparam int MAX_RD_LATENCY = 4;
  localparam int ERR_CNT_W      = 16;

  // Classification of a word address against one bank's window.
  typedef enum logic [1:0] {
    DEC_NONE     = 2'd0,  // outside the window, owned by another bank
    DEC_SW       = 2'd1,  // software read/write register
    DEC_HW       = 2'd2,  // hardware read-only status word
    DEC_UNMAPPED = 2'd3   // inside the window but backed by nothing
  } dec_kind_e;

endpackage

// File: rtl/mmio_rd_pipe.sv
// Fixed-depth valid/tid/data delay line for read responses. Payload stages
// only load on a valid beat, so the output payload holds the last response.
module mmio_rd_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int TID_WIDTH  = 9,
  parameter int STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  input  logic [TID_WIDTH-1:0]  req_tid,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_vld,
  output logic [TID_WIDTH-1:0]  rsp_tid,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  logic                  vld_p  [STAGES];
  logic [TID_WIDTH-1:0]  tid_p  [STAGES];
  logic [DATA_WIDTH-1:0] data_p [STAGES];

  // Shift valid every cycle; advance payload only alongside a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_p[i]  <= 1'b0;
        tid_p[i]  <= '0;
        data_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= req_vld;
      if (req_vld) begin
        tid_p[0]  <= req_tid;
        data_p[0] <= req_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) begin
          tid_p[i]  <= tid_p[i-1];
          data_p[i] <= data_p[i-1];
        end
      end
    end
  end

  assign rsp_vld  = vld_p[STAGES-1];
  assign rsp_tid  = tid_p[STAGES-1];
  assign rsp_data = data_p[STAGES-1];

endmodule

// File: rtl/mmio_reg_bank.sv
// MMIO register bank: software R/W registers followed by hardware status
// words inside a word-address window, with a fixed-latency read response
// and a start pulse on writes of bit 0 to the first register.
// Optional feature: define MMIO_ERR_CNT_EN to add the err_count output that
// counts accesses to unmapped offsets and writes to status offsets.
module mmio_reg_bank
  import mmio_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 16,
  parameter int START_ADDR  = 'h20,
  parameter int END_ADDR    = 'h3F,
  parameter int NUM_SW_REGS = 8,
  parameter int NUM_HW_REGS = 4,
  parameter int TID_WIDTH   = 9,
  parameter int RD_LATENCY  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_en,
  input  logic [ADDR_WIDTH-1:0]             rd_addr,
  input  logic [TID_WIDTH-1:0]              rd_tid,
  input  logic                              wr_en,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              rd_valid,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [TID_WIDTH-1:0]              rd_rsp_tid,
  output logic [NUM_SW_REGS*DATA_WIDTH-1:0] sw_regs,
  input  logic [NUM_HW_REGS*DATA_WIDTH-1:0] hw_status,
  output logic                              go
`ifdef MMIO_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]              err_count
`endif
);

  localparam int SW_IDX_W = (NUM_SW_REGS > 1) ? $clog2(NUM_SW_REGS) : 1;
  localparam int HW_IDX_W = (NUM_HW_REGS > 1) ? $clog2(NUM_HW_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SW_N    = ADDR_WIDTH'(NUM_SW_REGS);
  localparam logic [ADDR_WIDTH-1:0] SW_HW_N = ADDR_WIDTH'(NUM_SW_REGS + NUM_HW_REGS);

  if ((NUM_SW_REGS + NUM_HW_REGS > END_ADDR - START_ADDR + 1) || (NUM_SW_REGS < 1) ||
      (RD_LATENCY < 1) || (RD_LATENCY > MAX_RD_LATENCY)) begin : g_bad_params
    $error("mmio_reg_bank: illegal parameter combination");
  end

  function automatic dec_kind_e decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - START_A;
    if (addr < START_A || addr > END_A) return DEC_NONE;
    else if (off < SW_N)                return DEC_SW;
    else if (off < SW_HW_N)             return DEC_HW;
    else                                return DEC_UNMAPPED;
  endfunction

  logic [DATA_WIDTH-1:0] sw_q [NUM_SW_REGS];
  logic [DATA_WIDTH-1:0] hw_w [NUM_HW_REGS];
  dec_kind_e             rd_kind, wr_kind;
  logic [SW_IDX_W-1:0]   rd_sw_idx, wr_sw_idx;
  logic [HW_IDX_W-1:0]   rd_hw_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  for (genvar i = 0; i < NUM_SW_REGS; i++) begin : g_sw_out
    assign sw_regs[i*DATA_WIDTH +: DATA_WIDTH] = sw_q[i];
  end
  for (genvar i = 0; i < NUM_HW_REGS; i++) begin : g_hw_in
    assign hw_w[i] = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rd_kind   = decode(rd_addr);
  assign wr_kind   = decode(wr_addr);
  assign rd_sw_idx = SW_IDX_W'(rd_addr - START_A);
  assign wr_sw_idx = SW_IDX_W'(wr_addr - START_A);
  assign rd_hw_idx = HW_IDX_W'(rd_addr - START_A - SW_N);

  // Read data is sampled in the request cycle, before any same-cycle write lands.
  always_comb begin
    rd_word = '0;
    case (rd_kind)
      DEC_SW:  rd_word = sw_q[rd_sw_idx];
      DEC_HW:  rd_word = hw_w[rd_hw_idx];
      default: rd_word = '0;
    endcase
  end

  // Software register file; writes outside the SW offsets are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SW_REGS; i++) sw_q[i] <= '0;
    end else if (wr_en && wr_kind == DEC_SW) begin
      sw_q[wr_sw_idx] <= wr_data;
    end
  end

  // Start pulse: one cycle after a write of bit 0 to the first register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) go <= 1'b0;
    else     go <= wr_en && (wr_addr == START_A) && wr_data[0];
  end

  mmio_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .TID_WIDTH  (TID_WIDTH),
    .STAGES     (RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (rd_en && rd_kind != DEC_NONE),
    .req_tid  (rd_tid),
    .req_data (rd_word),
    .rsp_vld  (rd_valid),
    .rsp_tid  (rd_rsp_tid),
    .rsp_data (rd_data)
  );

`ifdef MMIO_ERR_CNT_EN
  logic rd_err, wr_err;

  function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                   input logic [1:0] inc);
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, a} + {{(ERR_CNT_W-1){1'b0}}, inc};
    return sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : sum[ERR_CNT_W-1:0];
  endfunction

  assign rd_err = rd_en && (rd_kind == DEC_UNMAPPED);
  assign wr_err = wr_en && (wr_kind == DEC_HW || wr_kind == DEC_UNMAPPED);

  // Saturating count of bad accesses; a read and a write error together add two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count <= '0;
    else     err_count <= sat_add(err_count, {1'b0, rd_err} + {1'b0, wr_err});
  end
`endif

endmodule

// File: tb/tb_mmio_reg_bank.sv
// Scoreboard bench for mmio_reg_bank: three banks at read latencies 1, 3 and 4
// share one randomized stimulus stream and are checked against a register model.
module tb_mmio_reg_bank;

  localparam int NI = 3;
  localparam int LATS [NI] = '{1, 3, 4};

  typedef struct packed {
    int          due;
    logic [8:0]  tid;
    logic [63:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_en = 1'b0, wr_en = 1'b0;
  logic [15:0]  rd_addr = '0, wr_addr = '0;
  logic [8:0]   rd_tid = '0;
  logic [63:0]  wr_data = '0;
  logic [255:0] hw_status = '0;

  logic         rd_valid_a [NI];
  logic [63:0]  rd_data_a  [NI];
  logic [8:0]   tid_a      [NI];
  logic [511:0] sw_a       [NI];
  logic         go_a       [NI];
`ifdef MMIO_ERR_CNT_EN
  logic [15:0]  err_a      [NI];
`endif

  // Reference model state
  logic [63:0] sw_m [8];
  int          go_due = -1;
  int          err_m  = 0;
  exp_t        exp_q [NI][$];
  logic [63:0] last_d [NI];
  logic [8:0]  last_t [NI];

  int ecnt   = 0;
  int n_chk  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mmio_reg_bank #(.RD_LATENCY(LATS[g])) u_dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_tid     (rd_tid),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_valid   (rd_valid_a[g]),
      .rd_data    (rd_data_a[g]),
      .rd_rsp_tid (tid_a[g]),
      .sw_regs    (sw_a[g]),
      .hw_status  (hw_status),
      .go         (go_a[g])
`ifdef MMIO_ERR_CNT_EN
      ,
      .err_count  (err_a[g])
`endif
    );
  end

  task automatic chk(input string nm, input int lat, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat %0d) at edge %0d: got %0h, expected %0h", nm, lat, ecnt, act, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input int off);
    if (off < 8)       return sw_m[off];
    else if (off < 12) return hw_status[(off-8)*64 +: 64];
    else               return 64'h0;
  endfunction

  // One bus cycle: drive, then update the model (read sees pre-write state).
  task automatic cycle(input bit re, input logic [15:0] ra, input logic [8:0] rt,
                       input bit we, input logic [15:0] wa, input logic [63:0] wd);
    int   roff, woff;
    exp_t e;
    @(negedge clk); #1;
    for (int k = 0; k < 4; k++) hw_status[k*64 +: 64] = {$urandom, $urandom};
    rd_en = re; rd_addr = ra; rd_tid = rt;
    wr_en = we; wr_addr = wa; wr_data = wd;
    roff = int'(ra) - 'h20;
    woff = int'(wa) - 'h20;
    if (re && roff >= 0 && roff <= 'h1F) begin
      e.tid  = rt;
      e.data = model_rd(roff);
      for (int i = 0; i < NI; i++) begin
        e.due = ecnt + LATS[i];
        exp_q[i].push_back(e);
      end
      if (roff >= 12 && err_m < 'hFFFF) err_m++;
    end
    if (we && woff >= 0 && woff <= 'h1F) begin
      if (woff < 8) begin
        sw_m[woff] = wd;
        if (woff == 0 && wd[0]) go_due = ecnt + 1;
      end else if (err_m < 'hFFFF) begin
        err_m++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 16'h0, 9'h0, 1'b0, 16'h0, 64'h0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); #1;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < NI; i++) exp_q[i].delete();
    for (int j = 0; j < 8; j++) sw_m[j] = '0;
    go_due = -1;
    err_m  = 0;
    repeat (n) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: pop expected responses and compare every observable output.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        last_d[i] = '0;
        last_t[i] = '0;
      end
      while (exp_q[i].size() > 0 && exp_q[i][0].due < ecnt) begin
        e = exp_q[i].pop_front();
        chk("rd_valid missing", LATS[i], 64'(rd_valid_a[i]), 64'd1);
      end
      if (rd_valid_a[i]) begin
        if (exp_q[i].size() == 0 || exp_q[i][0].due != ecnt) begin
          chk("rd_valid unexpected", LATS[i], 64'(rd_valid_a[i]), 64'd0);
        end else begin
          e = exp_q[i].pop_front();
          chk("rd_data", LATS[i], rd_data_a[i], e.data);
          chk("rd_rsp_tid", LATS[i], 64'(tid_a[i]), 64'(e.tid));
          last_d[i] = e.data;
          last_t[i] = e.tid;
        end
      end else begin
        if (exp_q[i].size() > 0 && exp_q[i][0].due == ecnt) begin
          e = exp_q[i].pop_front();
          chk("rd_valid", LATS[i], 64'(rd_valid_a[i]), 64'd1);
        end
        chk("rd_data hold", LATS[i], rd_data_a[i], last_d[i]);
        chk("rd_rsp_tid hold", LATS[i], 64'(tid_a[i]), 64'(last_t[i]));
      end
      for (int j = 0; j < 8; j++) chk($sformatf("sw_regs[%0d]", j), LATS[i], sw_a[i][j*64 +: 64], sw_m[j]);
      chk("go", LATS[i], 64'(go_a[i]), 64'(go_due == ecnt));
`ifdef MMIO_ERR_CNT_EN
      chk("err_count", LATS[i], 64'(err_a[i]), 64'(err_m));
`endif
    end
    if (done) begin
      for (int i = 0; i < NI; i++) chk("responses outstanding", LATS[i], 64'(exp_q[i].size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    for (int j = 0; j < 8; j++) sw_m[j] = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Write then read back a SW register with tid 5
    cycle(1'b0, 16'h0, 9'd0, 1'b1, 16'h21, 64'h1234);
    cycle(1'b1, 16'h21, 9'd5, 1'b0, 16'h0, 64'h0);
    idle(5);

    // Start pulse from bit 0 of register 0
    cycle(1'b0, 16'h0, 9'd0, 1'b1, 16'h20, 64'h1);
    idle(3);

    // Back-to-back reads, tids 1..4
    for (int t = 1; t <= 4; t++) cycle(1'b1, 16'(16'h20 + t), 9'(t), 1'b0, 16'h0, 64'h0);
    idle(6);

    // Out-of-range read, unmapped read, status read
    cycle(1'b1, 16'h40, 9'd7, 1'b0, 16'h0, 64'h0);
    cycle(1'b1, 16'h2F, 9'd8, 1'b0, 16'h0, 64'h0);
    cycle(1'b1, 16'h29, 9'd12, 1'b0, 16'h0, 64'h0);
    idle(5);

    // Same-cycle read and write of one register
    cycle(1'b0, 16'h0, 9'd0, 1'b1, 16'h22, 64'h55);
    cycle(1'b1, 16'h22, 9'd9, 1'b1, 16'h22, 64'hAA);
    cycle(1'b1, 16'h22, 9'd10, 1'b0, 16'h0, 64'h0);
    idle(5);

    // Reset with reads in flight
    cycle(1'b1, 16'h23, 9'd11, 1'b0, 16'h0, 64'h0);
    do_reset(2);
    idle(8);

    // Randomized traffic around and inside the window
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom_range('h1C, 'h43)), 9'($urandom),
            1'($urandom_range(0, 1)), 16'($urandom_range('h1C, 'h43)), {$urandom, $urandom});
    end
    idle(8);
    done = 1'b1;

    repeat (5) @(negedge clk);
    $display("FAIL watchdog: monitor did not finish");
    $fatal(1, "watchdog");
  end

endmodule
